pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 54 +++++
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Pipeline-control bundle between the EX/ID stages, the
//                interrupt source and the PC / if_id / id_ex registers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
   // Pipeline status towards the controller
   logic        jump_req_i;
   logic [31:0] jump_addr_i;
   logic [31:0] ex_pc_i;
   logic        mc_start_i;
   logic        mc_done_i;
   logic        ex_load_i;
   logic [4:0]  ex_rd_i;
   logic [4:0]  id_rs1_i;
   logic [4:0]  id_rs2_i;
   logic        id_rs1_re_i;
   logic        id_rs2_re_i;
   logic        int_req_i;
   logic [31:0] int_addr_i;

   // Control back to the pipeline
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        pc_hold_o;
   logic        if_id_stall_o;
   logic        if_id_flush_o;
   logic        id_ex_stall_o;
   logic        id_ex_flush_o;
   logic        int_ack_o;
   logic [31:0] epc_o;
   logic        mc_timeout_o;

   // Pipeline side: drives status, receives control
   modport master (
      output jump_req_i, jump_addr_i, ex_pc_i, mc_start_i, mc_done_i,
             ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
             int_req_i, int_addr_i,
      input  jump_flag_o, jump_addr_o, pc_hold_o, if_id_stall_o, if_id_flush_o,
             id_ex_stall_o, id_ex_flush_o, int_ack_o, epc_o, mc_timeout_o
   );

   // Controller side
   modport slave (
      input  jump_req_i, jump_addr_i, ex_pc_i, mc_start_i, mc_done_i,
             ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
             int_req_i, int_addr_i,
      output jump_flag_o, jump_addr_o, pc_hold_o, if_id_stall_o, if_id_flush_o,
             id_ex_stall_o, id_ex_flush_o, int_ack_o, epc_o, mc_timeout_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hazard / redirect controller. Handles interrupts,
//                EX-stage jumps with post-redirect if_id flushing, multi-cycle
//                EX operations with timeout, and load-use stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 1,   // extra if_id flush cycles after redirect, 0..7
   parameter int MC_TIMEOUT   = 64   // max cycles in MC_WAIT, 2..255
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_MC_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] c_flush_load = 8'(FLUSH_CYCLES);
   localparam logic [7:0] c_mc_last    = 8'(MC_TIMEOUT - 1);
   // With no fetch latency to cover, a redirect leaves the FSM in IDLE.
   localparam state_t     c_after_redir = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_IDLE;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;            // flush cycles left / MC_WAIT cycles spent
   logic        int_ack_q, int_ack_d;
   logic [31:0] epc_q, epc_d;
   logic        mc_timeout_q, mc_timeout_d;

   logic        w_rs1_hit;
   logic        w_rs2_hit;
   logic        w_load_use;
   logic        w_jump_flag;
   logic [31:0] w_jump_addr;
   logic        w_pc_hold;
   logic        w_if_id_stall;
   logic        w_if_id_flush;
   logic        w_id_ex_stall;
   logic        w_id_ex_flush;

   assign w_rs1_hit  = bus.id_rs1_re_i && (bus.id_rs1_i == bus.ex_rd_i);
   assign w_rs2_hit  = bus.id_rs2_re_i && (bus.id_rs2_i == bus.ex_rd_i);
   assign w_load_use = bus.ex_load_i && (bus.ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);

   // Next-state and combinational control outputs
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      int_ack_d     = 1'b0;
      epc_d         = epc_q;
      mc_timeout_d  = 1'b0;
      w_jump_flag   = 1'b0;
      w_jump_addr   = 32'd0;
      w_pc_hold     = 1'b0;
      w_if_id_stall = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_stall = 1'b0;
      w_id_ex_flush = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.int_req_i) begin
               // Interrupt pre-empts a simultaneous jump; the jump target becomes the return address.
               w_jump_flag   = 1'b1;
               w_jump_addr   = bus.int_addr_i;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
               int_ack_d     = 1'b1;
               epc_d         = bus.jump_req_i ? bus.jump_addr_i : bus.ex_pc_i;
               state_d       = c_after_redir;
               cnt_d         = c_flush_load;
            end else if (bus.jump_req_i) begin
               w_jump_flag   = 1'b1;
               w_jump_addr   = bus.jump_addr_i;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
               state_d       = c_after_redir;
               cnt_d         = c_flush_load;
            end else if (bus.mc_start_i) begin
               state_d = ST_MC_WAIT;
               cnt_d   = 8'd0;
            end else if (w_load_use) begin
               w_pc_hold     = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_flush = 1'b1;
            end
         end

         ST_FLUSH: begin
            w_if_id_flush = 1'b1;
            if (bus.jump_req_i) begin
               // A new redirect restarts the flush window.
               w_jump_flag   = 1'b1;
               w_jump_addr   = bus.jump_addr_i;
               w_id_ex_flush = 1'b1;
               cnt_d         = c_flush_load;
            end else if (cnt_q <= 8'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         ST_MC_WAIT: begin
            if (bus.mc_done_i) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else begin
               w_pc_hold     = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_stall = 1'b1;
               if (cnt_q >= c_mc_last) begin
                  state_d      = ST_IDLE;
                  cnt_d        = 8'd0;
                  mc_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State, counter and registered outputs; reset acts immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         int_ack_q    <= 1'b0;
         epc_q        <= 32'd0;
         mc_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         int_ack_q    <= int_ack_d;
         epc_q        <= epc_d;
         mc_timeout_q <= mc_timeout_d;
      end
   end

   assign bus.jump_flag_o   = w_jump_flag;
   assign bus.jump_addr_o   = w_jump_flag ? w_jump_addr : 32'd0;
   assign bus.pc_hold_o     = w_pc_hold;
   // Flush always wins over a stall on the same stage.
   assign bus.if_id_stall_o = w_if_id_stall & ~w_if_id_flush;
   assign bus.if_id_flush_o = w_if_id_flush;
   assign bus.id_ex_stall_o = w_id_ex_stall & ~w_id_ex_flush;
   assign bus.id_ex_flush_o = w_id_ex_flush;
   assign bus.int_ack_o     = int_ack_q;
   assign bus.epc_o         = epc_q;
   assign bus.mc_timeout_o  = mc_timeout_q;

endmodule
`default_nettype wire
